// File: rtl/mem_reg_arbiter_pkg.sv
// mem_reg_pkg: shared definitions for the host/FPGA command register file.
//   ADDR_W, DATA_W, DEPTH, STATUS_BASE : register file geometry
//   REG_*                              : named register addresses
//   arb_state_t                        : write-port arbiter states
//   in_status()                        : true for FPGA-owned status addresses
package mem_reg_pkg;

   localparam int unsigned ADDR_W      = 5;
   localparam int unsigned DATA_W      = 16;
   localparam int unsigned DEPTH       = 2 ** ADDR_W;
   localparam int unsigned STATUS_BASE = 16;

   localparam logic [ADDR_W-1:0] REG_CTRL       = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] REG_SAMPLE_CNT = ADDR_W'(16);
   localparam logic [ADDR_W-1:0] REG_SPIKE_CNT  = ADDR_W'(17);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      COMMIT = 1'b1
   } arb_state_t;

   function automatic logic in_status(input logic [ADDR_W-1:0] a);
      return a >= ADDR_W'(STATUS_BASE);
   endfunction

endpackage

// File: rtl/mem_reg_arbiter_if.sv
// mem_reg_arbiter_if: host bus plus internal status-requester bus.
//   host_din/host_we/host_re/host_addr -> arbiter, host_dout <- arbiter
//   req/req_addr/req_data -> arbiter (packed, requester i at [i*W +: W])
//   gnt/req_err <- arbiter (one-cycle pulses)
// Modports: master = host + requesters, slave = arbiter.
interface mem_reg_arbiter_if
   import mem_reg_pkg::*;
#(
   parameter int unsigned N_REQ = 4
);
   logic [DATA_W-1:0]       host_din;
   logic                    host_we;
   logic                    host_re;
   logic [ADDR_W-1:0]       host_addr;
   logic [DATA_W-1:0]       host_dout;
   logic [N_REQ-1:0]        req;
   logic [N_REQ*ADDR_W-1:0] req_addr;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        gnt;
   logic [N_REQ-1:0]        req_err;

   modport master (
      output host_din, host_we, host_re, host_addr, req, req_addr, req_data,
      input  host_dout, gnt, req_err
   );

   modport slave (
      input  host_din, host_we, host_re, host_addr, req, req_addr, req_data,
      output host_dout, gnt, req_err
   );
endinterface

// File: rtl/mem_reg_arbiter_rr_pick.sv
// rr_pick: combinational round-robin first-set finder.
//   req   : request vector
//   ptr   : index searched first; search wraps past N-1 to 0
//   idx   : first asserted index at or after ptr
//   valid : any request asserted
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned PW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] idx,
   output logic          valid
);
   int unsigned j;

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!valid && req[j]) begin
            valid = 1'b1;
            idx   = PW'(j);
         end
      end
   end
endmodule

// File: rtl/mem_reg_arbiter.sv
// mem_reg_arbiter: 32x16 host/FPGA command register file with a single
// arbitrated write port. The host has absolute priority (writes never stall,
// reads registered); N_REQ internal reporters share the remaining cycles
// round-robin with a req/gnt handshake into the status region.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus (slave)   : host read/write port and packed requester req/gnt bus
//   sync_en       : reg[REG_CTRL] bit 0, double-registered
//   host_ro_viol  : sticky, host wrote into the status region
//   starve        : sticky starvation flag
// Build option: MEM_REG_ARB_STARVE_EN enables the wait counter behind
// starve; without it starve is tied low.
module mem_reg_arbiter
   import mem_reg_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned STARVE_MAX = 255
) (
   input  logic             clk,
   input  logic             rst,
   mem_reg_arbiter_if.slave bus,
   output logic             sync_en,
   output logic             host_ro_viol,
   output logic             starve
);
   localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [DATA_W-1:0] regs [DEPTH];
   arb_state_t        state;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     lat_idx;
   logic [PW-1:0]     pick_idx;
   logic              pick_valid;
   logic [ADDR_W-1:0] lat_addr;
   logic [ADDR_W-1:0] pick_addr;
   logic [DATA_W-1:0] lat_data;
   logic [DATA_W-1:0] pick_data;
   logic              host_busy;
   logic              sync_en_buf;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
      return (i == PW'(N_REQ - 1)) ? '0 : i + 1'b1;
   endfunction

   rr_pick #(
      .N  (N_REQ),
      .PW (PW)
   ) u_pick (
      .req   (bus.req),
      .ptr   (rr_ptr),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   always_comb begin
      host_busy = bus.host_we | bus.host_re;
      pick_addr = bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
      pick_data = bus.req_data[pick_idx*DATA_W +: DATA_W];
   end

   // Host and internal writes never coincide: COMMIT only writes when the
   // host is idle, so the two regs[] assignments below are exclusive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned a = 0; a < DEPTH; a++) regs[a] <= '0;
         state         <= IDLE;
         rr_ptr        <= '0;
         lat_idx       <= '0;
         lat_addr      <= '0;
         lat_data      <= '0;
         bus.gnt       <= '0;
         bus.req_err   <= '0;
         bus.host_dout <= '0;
         host_ro_viol  <= 1'b0;
         sync_en_buf   <= 1'b0;
         sync_en       <= 1'b0;
      end else begin
         bus.gnt     <= '0;
         bus.req_err <= '0;
         sync_en_buf <= regs[REG_CTRL][0];
         sync_en     <= sync_en_buf;

         if (bus.host_re) bus.host_dout <= regs[bus.host_addr];
         if (bus.host_we) begin
            if (in_status(bus.host_addr)) host_ro_viol <= 1'b1;
            else regs[bus.host_addr] <= bus.host_din;
         end

         case (state)
            IDLE: begin
               if (pick_valid) begin
                  if (in_status(pick_addr)) begin
                     lat_idx  <= pick_idx;
                     lat_addr <= pick_addr;
                     lat_data <= pick_data;
                     state    <= COMMIT;
                  end else begin
                     bus.req_err[pick_idx] <= 1'b1;
                     rr_ptr <= next_ptr(pick_idx);
                  end
               end
            end
            COMMIT: begin
               if (!host_busy) begin
                  regs[lat_addr]   <= lat_data;
                  bus.gnt[lat_idx] <= 1'b1;
                  rr_ptr           <= next_ptr(lat_idx);
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef MEM_REG_ARB_STARVE_EN
   logic [7:0] wait_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         starve   <= 1'b0;
      end else begin
         if (state == COMMIT) begin
            if (host_busy) begin
               if (wait_cnt != 8'hFF) wait_cnt <= wait_cnt + 8'd1;
            end else begin
               wait_cnt <= '0;
            end
         end
         if (32'(wait_cnt) >= STARVE_MAX) starve <= 1'b1;
      end
   end
`else
   assign starve = 1'b0;
`endif

endmodule

// File: tb/tb_mem_reg_arbiter.sv
module tb_mem_reg_arbiter;
   import mem_reg_pkg::*;

   localparam int unsigned N = 4;

   logic clk = 1'b0;
   logic rst;
   logic sync_en, host_ro_viol, starve;

   mem_reg_arbiter_if #(.N_REQ(N)) bus ();

   mem_reg_arbiter #(
      .N_REQ      (N),
      .STARVE_MAX (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .sync_en      (sync_en),
      .host_ro_viol (host_ro_viol),
      .starve       (starve)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } item_t;

   typedef struct {
      bit err;
      int idx;
      int cyc;
   } ev_t;

   item_t             rq [N][$];
   ev_t               evq[$];
   logic [DATA_W-1:0] rdq[$];
   logic [DATA_W-1:0] mdl [DEPTH];
   int                rr_model;
   bit                exp_reg0b0, exp_viol;
   int                total = 0, bad = 0, cyc = 0;
   bit                mon_en = 0;
   bit                m_rd, m_s, m_v, m_rst, s1, s2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic ev_check(input bit err, input int idx);
      ev_t e;
      total++;
      if (evq.size() == 0) begin
         bad++;
         $display("FAIL event: got %s[%0d] at cyc %0d, expected none", err ? "req_err" : "gnt", idx, cyc);
      end else begin
         e = evq.pop_front();
         if (e.err != err || e.idx != idx || e.cyc != cyc) begin
            bad++;
            $display("FAIL event: got %s[%0d] at cyc %0d, expected %s[%0d] at cyc %0d",
                     err ? "req_err" : "gnt", idx, cyc, e.err ? "req_err" : "gnt", e.idx, e.cyc);
         end
      end
   endtask

   // Monitor: samples at posedge + 1, stimulus runs at posedge + 2.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         m_rst = rst;
         m_rd  = bus.host_re;
         m_s   = exp_reg0b0;
         m_v   = exp_viol;
         #1;
         if (m_rst || rst) begin
            s1 = 1'b0;
            s2 = 1'b0;
         end else if (mon_en) begin
            if (m_rd) begin
               if (rdq.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL host_dout: read with no expectation queued (cyc %0d)", cyc);
               end else begin
                  chk("host_dout", 32'(bus.host_dout), 32'(rdq.pop_front()));
               end
            end
            for (int i = 0; i < N; i++) begin
               if (bus.gnt[i])     ev_check(1'b0, i);
               if (bus.req_err[i]) ev_check(1'b1, i);
            end
            chk("sync_en", 32'(sync_en), 32'(s2));
            s2 = s1;
            s1 = m_s;
            chk("host_ro_viol", 32'(host_ro_viol), 32'(m_v));
`ifndef MEM_REG_ARB_STARVE_EN
            chk("starve_off", 32'(starve), 0);
`endif
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.host_we = 1'b0; bus.host_re = 1'b0; bus.host_addr = '0; bus.host_din = '0;
      bus.req = '0; bus.req_addr = '0; bus.req_data = '0;
      for (int i = 0; i < N; i++) rq[i].delete();
      evq.delete();
      rdq.delete();
      for (int a = 0; a < DEPTH; a++) mdl[a] = '0;
      rr_model = 0;
      exp_reg0b0 = 1'b0;
      exp_viol = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   task automatic check_zero();
      chk("rst_host_dout", 32'(bus.host_dout), 0);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_req_err", 32'(bus.req_err), 0);
      chk("rst_sync_en", 32'(sync_en), 0);
      chk("rst_ro_viol", 32'(host_ro_viol), 0);
      chk("rst_starve", 32'(starve), 0);
   endtask

   // One host bus cycle; model updated with the state after the next edge.
   task automatic host_cycle(input bit we, input bit re, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.host_we = we; bus.host_re = re; bus.host_addr = a; bus.host_din = d;
      if (re) rdq.push_back(mdl[a]);
      if (we) begin
         if (int'(a) >= STATUS_BASE) exp_viol = 1'b1;
         else begin
            mdl[a] = d;
            if (a == '0) exp_reg0b0 = d[0];
         end
      end
      @(posedge clk);
      #2;
      bus.host_we = 1'b0;
      bus.host_re = 1'b0;
   endtask

   // Reference: every arbitration picks the first requester with work at or
   // after the pointer; a reject costs one cycle, a commit two.
   task automatic plan_reqs(input int extra);
      int pos[N];
      int left = 0;
      int c = extra;
      int c0 = cyc;
      int pick;
      item_t it;
      for (int i = 0; i < N; i++) begin
         pos[i] = 0;
         left += rq[i].size();
      end
      while (left > 0) begin
         pick = -1;
         for (int k = 0; k < N; k++) begin
            int j = (rr_model + k) % N;
            if (pick < 0 && pos[j] < rq[j].size()) pick = j;
         end
         it = rq[pick][pos[pick]];
         pos[pick]++;
         left--;
         if (int'(it.a) < STATUS_BASE) begin
            evq.push_back('{1'b1, pick, c0 + c + 1});
            c += 1;
         end else begin
            evq.push_back('{1'b0, pick, c0 + c + 2});
            c += 2;
            mdl[it.a] = it.d;
         end
         rr_model = (pick + 1) % N;
      end
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += rq[i].size();
      return s;
   endfunction

   task automatic drive_reqs();
      for (int i = 0; i < N; i++) begin
         if (rq[i].size() > 0) begin
            bus.req[i] = 1'b1;
            bus.req_addr[i*ADDR_W +: ADDR_W] = rq[i][0].a;
            bus.req_data[i*DATA_W +: DATA_W] = rq[i][0].d;
         end else begin
            bus.req[i] = 1'b0;
         end
      end
   endtask

   task automatic run_reqs(input int extra);
      int n = 0;
      plan_reqs(extra);
      drive_reqs();
      while (pending() > 0 && n < 400) begin
         @(posedge clk);
         #2;
         n++;
         for (int i = 0; i < N; i++)
            if ((bus.gnt[i] || bus.req_err[i]) && rq[i].size() > 0) rq[i].delete(0);
         drive_reqs();
      end
      chk("req_done_in_budget", 32'(pending()), 0);
      n = 0;
      while (evq.size() > 0 && n < 20) begin
         @(posedge clk);
         #2;
         n++;
      end
      chk("events_drained", 32'(evq.size()), 0);
   endtask

   initial begin
      rst = 1'b1;
      do_reset();
      mon_en = 1'b1;
      check_zero();

      // Reset while a request sits latched in COMMIT: no grant, nothing written.
      rq[0].push_back('{ADDR_W'(17), DATA_W'($urandom)});
      drive_reqs();
      @(posedge clk);
      #2;
      do_reset();
      check_zero();
      host_cycle(1'b0, 1'b1, ADDR_W'(3), '0);
      host_cycle(1'b0, 1'b1, ADDR_W'(17), '0);

      // Control bit 0 write, read back, sync_en two edges after the write.
      host_cycle(1'b1, 1'b0, ADDR_W'(0), 16'h0001);
      chk("sync_en_e1", 32'(sync_en), 0);
      host_cycle(1'b0, 1'b1, ADDR_W'(0), '0);
      chk("sync_en_e2", 32'(sync_en), 0);
      @(posedge clk);
      #2;
      chk("sync_en_e3", 32'(sync_en), 1);

      // Single request, idle host: grant two cycles after request.
      rq[0].push_back('{ADDR_W'(16), 16'hABCD});
      run_reqs(0);
      host_cycle(1'b0, 1'b1, ADDR_W'(16), '0);

      // Host busy for 5 cycles holds off requester 1.
      rq[1].push_back('{ADDR_W'(18), DATA_W'($urandom)});
      fork
         run_reqs(4);
         for (int k = 0; k < 5; k++) host_cycle(1'b1, 1'b0, ADDR_W'(5 + k), DATA_W'($urandom));
      join

      // All four continuously requesting from pointer 0: 0,1,2,3,0.
      do_reset();
      check_zero();
      rq[0].push_back('{ADDR_W'(16), DATA_W'($urandom)});
      for (int i = 1; i < N; i++) rq[i].push_back('{ADDR_W'(16 + i), DATA_W'($urandom)});
      rq[0].push_back('{ADDR_W'(20), DATA_W'($urandom)});
      run_reqs(0);

      // Rejected request into host region; host write into status region.
      host_cycle(1'b1, 1'b0, ADDR_W'(4), 16'h5A5A);
      rq[2].push_back('{ADDR_W'(4), DATA_W'($urandom)});
      run_reqs(0);
      host_cycle(1'b0, 1'b1, ADDR_W'(4), '0);
      host_cycle(1'b1, 1'b0, ADDR_W'(20), 16'h1234);
      host_cycle(1'b0, 1'b1, ADDR_W'(20), '0);
      chk("ro_viol_set", 32'(host_ro_viol), 1);

      // Read and write of the same address in one cycle returns old data.
      host_cycle(1'b1, 1'b0, ADDR_W'(7), 16'h1111);
      host_cycle(1'b1, 1'b1, ADDR_W'(7), 16'hBEEF);
      host_cycle(1'b0, 1'b1, ADDR_W'(7), '0);

      // Random requester rounds: shared addresses, occasional rejects.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < N; i++) begin
            int cnt = $urandom_range(0, 3);
            for (int k = 0; k < cnt; k++) begin
               logic [ADDR_W-1:0] a;
               if ($urandom_range(0, 99) < 15) a = ADDR_W'($urandom_range(0, 15));
               else a = ADDR_W'($urandom_range(16, 20));
               rq[i].push_back('{a, DATA_W'($urandom)});
            end
         end
         run_reqs(0);
      end

      // Random host traffic.
      for (int k = 0; k < 80; k++) begin
         bit we = ($urandom_range(0, 1) == 1);
         bit re = ($urandom_range(0, 1) == 1);
         host_cycle(we, re, ADDR_W'($urandom_range(0, DEPTH - 1)), DATA_W'($urandom));
      end

      // Full read-back against the model.
      for (int a = 0; a < DEPTH; a++) host_cycle(1'b0, 1'b1, ADDR_W'(a), '0);

`ifdef MEM_REG_ARB_STARVE_EN
      rq[0].push_back('{ADDR_W'(21), DATA_W'($urandom)});
      fork
         run_reqs(9);
         for (int k = 0; k < 10; k++) host_cycle(1'b1, 1'b0, ADDR_W'(8), DATA_W'($urandom));
      join
      chk("starve_sticky", 32'(starve), 1);
`endif

      @(posedge clk);
      #2;
      chk("reads_drained", 32'(rdq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
